ddr_write_arbiter: RTL and testbench

- Shares one DDR S2MM write datamover front end among NUM_CH requesters (frame writers, log writers, etc.).
- Round-robin arbitration; one transfer at a time. Per grant: latches address/length, issues the start handshake, steers the granted channel's beat stream to the writer, then waits for the datamover status beat.
- Reports per-channel done/error.
- Sits between the requester blocks and the datamover write wrapper.

---
 rtl/ddr_write_arbiter_if.sv | 27 ++
 rtl/ddr_write_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_ddr_write_arbiter.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_write_arbiter_if.sv
// Writer-side bus of the DDR write arbiter: start command, beat stream and datamover status.
// The arbiter drives it through the master modport; the datamover write wrapper uses slave.
interface ddr_write_arbiter_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
);
    logic                  wr_start;
    logic                  wr_cmd_ready;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [LEN_WIDTH-1:0]  wr_len;
    logic                  wr_data_vld;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_ready;
    logic                  sts_vld;
    logic [7:0]            sts_data;

    modport master (
        output wr_start, wr_addr, wr_len, wr_data_vld, wr_data,
        input  wr_cmd_ready, wr_ready, sts_vld, sts_data
    );

    modport slave (
        input  wr_start, wr_addr, wr_len, wr_data_vld, wr_data,
        output wr_cmd_ready, wr_ready, sts_vld, sts_data
    );
endinterface

// File: rtl/ddr_write_arbiter.sv
// Round-robin arbiter sharing one S2MM datamover write front end among NUM_CH requesters.
// One transfer at a time: grant, start command, beat steering, status wait, done/err report.
module ddr_write_arbiter #(
    parameter int NUM_CH      = 4,
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 32,
    parameter int LEN_WIDTH   = 16,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            ch_req,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_addr,
    input  logic [NUM_CH*LEN_WIDTH-1:0]  ch_len,
    output logic [NUM_CH-1:0]            ch_grant,
    input  logic [NUM_CH-1:0]            ch_wdata_vld,
    input  logic [NUM_CH*DATA_WIDTH-1:0] ch_wdata,
    output logic [NUM_CH-1:0]            ch_wready,
    output logic [NUM_CH-1:0]            ch_done,
    output logic [NUM_CH-1:0]            ch_err,
    ddr_write_arbiter_if.master          wr,
    output logic                         busy
);
    localparam int BYTES_PER_BEAT = DATA_WIDTH / 8;
    localparam int BEAT_SHIFT     = $clog2(BYTES_PER_BEAT);
    localparam int PTR_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [LEN_WIDTH-1:0] LEN_LSB_MASK = LEN_WIDTH'(BYTES_PER_BEAT - 1);
    localparam logic [15:0]          TMO_LAST     = 16'(TIMEOUT_CYC - 1);
    localparam logic [PTR_W-1:0]     PTR_LAST     = PTR_W'(NUM_CH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_DATA,
        S_WAIT_STS,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [PTR_W-1:0]      r_ptr;
    logic [PTR_W-1:0]      r_sel;
    logic [NUM_CH-1:0]     r_grant;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  r_beats;
    logic [LEN_WIDTH-1:0]  r_beat_cnt;
    logic [15:0]           r_tmo;
    logic                  r_err;

    logic                  w_any_req;
    logic [PTR_W-1:0]      w_pick;
    logic [LEN_WIDTH-1:0]  w_len_pick;
    logic [LEN_WIDTH-1:0]  w_beats_pick;
    logic                  w_len_bad;
    logic [NUM_CH-1:0]     w_sel_oh;
    logic                  w_beat;
    logic                  w_last_beat;
    logic                  w_sts_err;
    logic                  w_tmo_hit;

    // First requester at or after the pointer; scanning downwards lets the nearest one win.
    function automatic logic [PTR_W-1:0] rr_pick(input logic [NUM_CH-1:0] req,
                                                 input logic [PTR_W-1:0]  ptr);
        logic [PTR_W-1:0] pick;
        logic [PTR_W-1:0] idx;
        pick = ptr;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = PTR_W'((int'(ptr) + i) % NUM_CH);
            if (req[idx]) begin
                pick = idx;
            end
        end
        return pick;
    endfunction

    assign w_any_req    = |ch_req;
    assign w_pick       = rr_pick(ch_req, r_ptr);
    assign w_len_pick   = ch_len[w_pick*LEN_WIDTH +: LEN_WIDTH];
    assign w_beats_pick = w_len_pick >> BEAT_SHIFT;
    assign w_len_bad    = (w_beats_pick == '0) || ((w_len_pick & LEN_LSB_MASK) != '0);

    assign w_sel_oh    = NUM_CH'(1) << r_sel;
    assign w_beat      = (r_state == S_DATA) && ch_wdata_vld[r_sel] && wr.wr_ready;
    assign w_last_beat = w_beat && (r_beat_cnt == r_beats - 1'b1);
    // Error unless OKAY is set and SLVERR/DECERR/INTERR are all clear.
    assign w_sts_err   = (wr.sts_data & 8'hF0) != 8'h80;
    assign w_tmo_hit   = (r_tmo == TMO_LAST);

    assign wr.wr_addr = r_addr;
    assign wr.wr_len  = r_len;
    assign ch_grant   = r_grant;
    assign busy       = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        wr.wr_start    = 1'b0;
        wr.wr_data_vld = 1'b0;
        wr.wr_data     = '0;
        ch_wready      = '0;
        ch_done        = '0;
        ch_err         = '0;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = w_len_bad ? S_DONE : S_CMD;
                end
            end
            S_CMD: begin
                wr.wr_start = 1'b1;
                if (wr.wr_cmd_ready) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                wr.wr_data_vld   = ch_wdata_vld[r_sel];
                wr.wr_data       = ch_wdata[r_sel*DATA_WIDTH +: DATA_WIDTH];
                ch_wready[r_sel] = wr.wr_ready;
                if (w_last_beat) begin
                    w_state_nxt = S_WAIT_STS;
                end
            end
            S_WAIT_STS: begin
                if (wr.sts_vld || w_tmo_hit) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                ch_done     = w_sel_oh;
                ch_err      = w_sel_oh & {NUM_CH{r_err}};
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Transfer context is captured at grant; a status beat outranks the timeout terminal count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr      <= '0;
            r_sel      <= '0;
            r_grant    <= '0;
            r_addr     <= '0;
            r_len      <= '0;
            r_beats    <= '0;
            r_beat_cnt <= '0;
            r_tmo      <= '0;
            r_err      <= 1'b0;
        end else begin
            r_grant <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_sel      <= w_pick;
                        r_grant    <= NUM_CH'(1) << w_pick;
                        r_ptr      <= (w_pick == PTR_LAST) ? '0 : w_pick + 1'b1;
                        r_addr     <= ch_addr[w_pick*ADDR_WIDTH +: ADDR_WIDTH];
                        r_len      <= w_len_pick;
                        r_beats    <= w_beats_pick;
                        r_beat_cnt <= '0;
                        r_tmo      <= '0;
                        r_err      <= w_len_bad;
                    end
                end
                S_DATA: begin
                    if (w_beat) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                    end
                end
                S_WAIT_STS: begin
                    if (wr.sts_vld) begin
                        r_err <= w_sts_err;
                    end else if (w_tmo_hit) begin
                        r_err <= 1'b1;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ddr_write_arbiter.sv
// Self-checking bench for ddr_write_arbiter: directed scenarios plus randomized transfers,
// checked against a transaction-level model of grant order, beat stream and done/err.
module tb_ddr_write_arbiter;
    localparam int NUM_CH      = 4;
    localparam int DATA_WIDTH  = 64;
    localparam int ADDR_WIDTH  = 32;
    localparam int LEN_WIDTH   = 16;
    localparam int TIMEOUT_CYC = 100;
    localparam int BPB         = DATA_WIDTH / 8;

    logic                         clk = 1'b0;
    logic                         rst;
    logic [NUM_CH-1:0]            ch_req;
    logic [NUM_CH*ADDR_WIDTH-1:0] ch_addr;
    logic [NUM_CH*LEN_WIDTH-1:0]  ch_len;
    logic [NUM_CH-1:0]            ch_grant;
    logic [NUM_CH-1:0]            ch_wdata_vld;
    logic [NUM_CH*DATA_WIDTH-1:0] ch_wdata;
    logic [NUM_CH-1:0]            ch_wready;
    logic [NUM_CH-1:0]            ch_done;
    logic [NUM_CH-1:0]            ch_err;
    logic                         busy;

    ddr_write_arbiter_if #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .LEN_WIDTH(LEN_WIDTH)) wrIf ();

    ddr_write_arbiter #(
        .NUM_CH(NUM_CH), .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
        .LEN_WIDTH(LEN_WIDTH), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst(rst), .ch_req(ch_req), .ch_addr(ch_addr), .ch_len(ch_len),
        .ch_grant(ch_grant), .ch_wdata_vld(ch_wdata_vld), .ch_wdata(ch_wdata),
        .ch_wready(ch_wready), .ch_done(ch_done), .ch_err(ch_err), .wr(wrIf), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int mPtr   = 0;
    logic [ADDR_WIDTH-1:0] cfgAddr [NUM_CH];
    logic [LEN_WIDTH-1:0]  cfgLen  [NUM_CH];
    logic [7:0] stsTable [6] = '{8'h80, 8'hC0, 8'hA0, 8'h90, 8'h00, 8'h88};

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus();
        for (int c = 0; c < NUM_CH; c++) begin
            ch_addr[c*ADDR_WIDTH +: ADDR_WIDTH] = cfgAddr[c];
            ch_len[c*LEN_WIDTH +: LEN_WIDTH]    = cfgLen[c];
        end
    endtask

    function automatic int rrPick(input logic [NUM_CH-1:0] req, input int ptr);
        for (int i = 0; i < NUM_CH; i++) begin
            if (req[(ptr + i) % NUM_CH]) return (ptr + i) % NUM_CH;
        end
        return -1;
    endfunction

    // One transfer from an IDLE cycle through DONE; stsDelay < 0 means the status never comes.
    task automatic runOne(input int cmdDelay, input int readyMode, input int stsDelay,
                          input logic [7:0] stsByte, input int abortBeat, input bit keepReq);
        int g, beats, idx, cyc, waitLen;
        logic bad, expErr;
        logic [NUM_CH-1:0] oh;
        logic [DATA_WIDTH-1:0] payload [$];
        applyStimulus();
        g = rrPick(ch_req, mPtr);
        if (g < 0) begin
            checkOutput("noRequester", 0, 1);
            return;
        end
        oh    = NUM_CH'(1) << g;
        beats = int'(cfgLen[g]) / BPB;
        bad   = (int'(cfgLen[g]) % BPB != 0) || (beats == 0);
        checkOutput("idleBusy", busy, 0);
        tick();
        checkOutput("grant", ch_grant, oh);
        mPtr = (g + 1) % NUM_CH;
        if (!keepReq) ch_req[g] = 1'b0;
        if (bad) begin
            checkOutput("badNoStart", wrIf.wr_start, 0);
            checkOutput("badDone", ch_done, oh);
            checkOutput("badErr", ch_err, oh);
            tick();
            checkOutput("badIdle", busy, 0);
            checkOutput("badNoStartAfter", wrIf.wr_start, 0);
            return;
        end
        for (int k = 0; k <= cmdDelay; k++) begin
            checkOutput("cmdStart", wrIf.wr_start, 1);
            checkOutput("cmdGrantPulse", ch_grant, (k == 0) ? oh : '0);
            checkOutput("cmdAddr", wrIf.wr_addr, cfgAddr[g]);
            checkOutput("cmdLen", wrIf.wr_len, cfgLen[g]);
            checkOutput("cmdNoWready", ch_wready, 0);
            wrIf.wr_cmd_ready = (k == cmdDelay);
            tick();
        end
        wrIf.wr_cmd_ready = 1'b0;
        checkOutput("startDrop", wrIf.wr_start, 0);
        for (int b = 0; b < beats; b++) payload.push_back({$urandom, $urandom});
        idx = 0;
        cyc = 0;
        while (idx < beats && cyc < 4 * beats + 20) begin
            for (int c = 0; c < NUM_CH; c++) begin
                ch_wdata[c*DATA_WIDTH +: DATA_WIDTH] = {$urandom, $urandom};
                ch_wdata_vld[c] = 1'($urandom_range(0, 1));
            end
            ch_wdata[g*DATA_WIDTH +: DATA_WIDTH] = payload[idx];
            ch_wdata_vld[g] = ($urandom_range(0, 3) != 0);
            case (readyMode)
                0:       wrIf.wr_ready = 1'b1;
                1:       wrIf.wr_ready = (cyc % 2 == 0);
                default: wrIf.wr_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            checkOutput("dataVld", wrIf.wr_data_vld, ch_wdata_vld[g]);
            if (ch_wdata_vld[g]) checkOutput("dataBeat", wrIf.wr_data, payload[idx]);
            checkOutput("dataWready", ch_wready, wrIf.wr_ready ? oh : '0);
            if (ch_wdata_vld[g] && wrIf.wr_ready) idx++;
            cyc++;
            tick();
            if (abortBeat >= 0 && idx == abortBeat) begin
                rst = 1'b1;
                ch_wdata_vld = '1;
                wrIf.wr_ready = 1'b1;
                tick();
                rst = 1'b0;
                checkOutput("rstBusy", busy, 0);
                checkOutput("rstGrant", ch_grant, 0);
                checkOutput("rstDone", ch_done, 0);
                checkOutput("rstWready", ch_wready, 0);
                checkOutput("rstDataVld", wrIf.wr_data_vld, 0);
                checkOutput("rstStart", wrIf.wr_start, 0);
                checkOutput("rstAddr", wrIf.wr_addr, 0);
                checkOutput("rstLen", wrIf.wr_len, 0);
                mPtr = 0;
                for (int k = 0; k < 3; k++) begin
                    tick();
                    checkOutput("rstNoDone", ch_done, 0);
                    checkOutput("rstIdle", busy, 0);
                end
                ch_wdata_vld = '0;
                wrIf.wr_ready = 1'b0;
                return;
            end
        end
        checkOutput("beatCount", idx, beats);
        ch_wdata_vld[g] = 1'b1;
        wrIf.wr_ready   = 1'b1;
        #1;
        checkOutput("gateVld", wrIf.wr_data_vld, 0);
        checkOutput("gateWready", ch_wready, 0);
        if (stsDelay < 0 || stsDelay > TIMEOUT_CYC - 1) begin
            expErr  = 1'b1;
            waitLen = TIMEOUT_CYC;
        end else begin
            expErr  = !stsByte[7] || (|stsByte[6:4]);
            waitLen = stsDelay + 1;
        end
        for (int k = 0; k < waitLen; k++) begin
            checkOutput("waitNoDone", ch_done, 0);
            checkOutput("waitBusy", busy, 1);
            wrIf.sts_vld  = (k == stsDelay);
            wrIf.sts_data = (k == stsDelay) ? stsByte : 8'($urandom);
            tick();
        end
        wrIf.sts_vld    = 1'b0;
        ch_wdata_vld    = '0;
        wrIf.wr_ready   = 1'b0;
        checkOutput("done", ch_done, oh);
        checkOutput("err", ch_err, expErr ? oh : '0);
        tick();
        checkOutput("idleAfterDone", busy, 0);
        checkOutput("donePulse", ch_done, 0);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1;
        ch_req = '0; ch_addr = '0; ch_len = '0; ch_wdata_vld = '0; ch_wdata = '0;
        wrIf.wr_cmd_ready = 1'b0; wrIf.wr_ready = 1'b0; wrIf.sts_vld = 1'b0; wrIf.sts_data = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            cfgAddr[c] = '0;
            cfgLen[c]  = '0;
        end
        tick();
        tick();
        checkOutput("resetBusy", busy, 0);
        checkOutput("resetGrant", ch_grant, 0);
        checkOutput("resetDone", ch_done, 0);
        checkOutput("resetErr", ch_err, 0);
        checkOutput("resetStart", wrIf.wr_start, 0);
        checkOutput("resetDataVld", wrIf.wr_data_vld, 0);
        rst = 1'b0;
        mPtr = 0;
        tick();

        $display("[TB] round robin, all channels requesting");
        for (int c = 0; c < NUM_CH; c++) begin
            cfgAddr[c] = 32'h2000_0000 + 32'(c) * 32'h100;
            cfgLen[c]  = 16'd8;
        end
        ch_req = '1;
        for (int t = 0; t < 5; t++) runOne(0, 0, 1, 8'h80, -1, 1'b1);
        ch_req = '0;

        $display("[TB] single transfer ch1 len 64");
        cfgAddr[1] = 32'h1000_0000; cfgLen[1] = 16'd64;
        ch_req = 4'b0010;
        runOne(0, 0, 2, 8'h80, -1, 1'b0);

        $display("[TB] bad lengths on ch2");
        cfgLen[2] = 16'd12; ch_req = 4'b0100;
        runOne(0, 0, 0, 8'h80, -1, 1'b0);
        cfgLen[2] = 16'd0; ch_req = 4'b0100;
        runOne(0, 0, 0, 8'h80, -1, 1'b0);

        $display("[TB] slow command, toggling ready, 16 beats");
        cfgAddr[3] = 32'h3000_0040; cfgLen[3] = 16'd128;
        cfgAddr[0] = 32'h0000_8000; cfgLen[0] = 16'd32;
        ch_req = 4'b1001;
        runOne(5, 1, 0, 8'h80, -1, 1'b0);
        $display("[TB] SLVERR status");
        runOne(1, 2, 3, 8'hC0, -1, 1'b0);

        $display("[TB] status timeout and tie with terminal count");
        cfgLen[1] = 16'd16; ch_req = 4'b0010;
        runOne(0, 0, -1, 8'h80, -1, 1'b0);
        cfgLen[2] = 16'd24; ch_req = 4'b0100;
        runOne(0, 0, TIMEOUT_CYC - 1, 8'h80, -1, 1'b0);

        $display("[TB] late status while idle");
        wrIf.sts_vld = 1'b1; wrIf.sts_data = 8'h00;
        tick();
        wrIf.sts_vld = 1'b0;
        checkOutput("lateStsBusy", busy, 0);
        checkOutput("lateStsDone", ch_done, 0);
        checkOutput("lateStsGrant", ch_grant, 0);

        $display("[TB] randomized transfers");
        for (int t = 0; t < 8; t++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                cfgAddr[c] = {$urandom} & 32'hFFFF_FFF8;
                if ($urandom_range(0, 9) == 0) cfgLen[c] = 16'(8 * $urandom_range(0, 8) + 4);
                else                           cfgLen[c] = 16'(8 * $urandom_range(1, 32));
            end
            ch_req = 4'($urandom_range(1, 15));
            runOne($urandom_range(0, 3), 2, $urandom_range(0, 5), stsTable[$urandom_range(0, 5)], -1, 1'b0);
        end
        ch_req = '0;

        $display("[TB] maximum length");
        cfgAddr[1] = 32'h4000_0000; cfgLen[1] = 16'hFFF8; ch_req = 4'b0010;
        runOne(0, 0, 1, 8'h80, -1, 1'b0);

        $display("[TB] reset in the middle of a transfer");
        cfgAddr[1] = 32'h5000_0000; cfgLen[1] = 16'd64; ch_req = 4'b0010;
        runOne(0, 0, 1, 8'h80, 3, 1'b0);
        cfgAddr[0] = 32'h6000_0000; cfgLen[0] = 16'd16;
        cfgAddr[3] = 32'h7000_0000; cfgLen[3] = 16'd16;
        ch_req = 4'b1001;
        runOne(0, 0, 0, 8'h80, -1, 1'b0);
        ch_req = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
